ber_sync_ctrl: RTL
==================

// Module: ber_sync_ctrl
// PURPOSE
//  Receive-side sequencer and reference-PRBS source feeding the BER counter stage.
//  Generates the local PRBS9 reference bit and the mode/strobe levels the counter samples on each i_ctrl strobe:
//  synchro_en, prbs_cmp_curr_addr_done and ber_counter_en.
//  Sweeps all candidate latencies, then switches the counter into BER-counting mode.
// PARAMETERS
//  PRBS_MAX_CYCLES  511     number of candidate latencies swept (addresses 0..PRBS_MAX_CYCLES-1)
//  WINDOW_LEN       511     i_ctrl strobes per address window (WINDOW_LEN-1 accumulate + 1 done); >=2
//  PRBS_SEED        9'h1AA  LFSR reset value; must be nonzero
//  RESYNC_HOLDOFF   4096    BER-mode strobes before i_ber_ok is trusted (AUTO_RESYNC_EN only)
// PORTS
//  clk                        in   1  clock
//  i_reset                    in   1  synchronous, active-high reset
//  i_en_rx                    in   1  receive enable; low acts as synchronous reset
//  i_ctrl                     in   1  one-cycle strobe at baud rate (1 per OS clocks)
//  i_ber_ok                   in   1  counter's ber-ok flag (used only with AUTO_RESYNC_EN)
//  o_prbs_bit                 out  1  reference PRBS bit -> counter i_new_bit_from_prbs
//  o_synchro_en               out  1  -> counter i_synchro_en
//  o_prbs_cmp_curr_addr_done  out  1  -> counter i_prbs_cmp_curr_addr_done
//  o_ber_counter_en           out  1  -> counter i_ber_counter_en
//  o_ber_clr                  out  1  one-clock clear pulse, OR'd into counter reset at top level
//  o_sync_done                out  1  high while in BER state
// BEHAVIOUR
//  - All outputs registered; reset / i_en_rx=0: state=IDLE, LFSR=PRBS_SEED, counters 0, all outputs 0.
//  - State/counter/LFSR updates only in clocks with i_ctrl=1; outputs hold between strobes,
//    so the counter samples each level exactly once.
//  - PRBS9 x^9+x^5+1: o_prbs_bit=lfsr[8]; shifts on each strobe in SYNC or BER; frozen in IDLE.
//  - FSM (2-bit):
//    IDLE: first strobe with i_en_rx=1 -> SYNC; o_synchro_en=1; win_cnt=0; addr_cnt=0.
//    SYNC: win_cnt increments each strobe.
//      o_prbs_cmp_curr_addr_done is high for exactly the strobe interval in which
//      win_cnt==WINDOW_LEN-1, then win_cnt wraps to 0 and addr_cnt increments.
//      After done for addr_cnt==PRBS_MAX_CYCLES-1 -> BER: o_synchro_en=0, o_ber_counter_en=1, o_sync_done=1.
//      Total SYNC length = PRBS_MAX_CYCLES*WINDOW_LEN strobes.
//    BER: terminal without AUTO_RESYNC_EN; the LFSR keeps running.
//  - Counter shifter-fill transient lands in window 0 (address 0); that candidate reads biased high, by design.
//  - i_reset or i_en_rx low mid-sweep: immediate return to IDLE, no done pulse emitted.
//  - Widths: win_cnt $clog2(WINDOW_LEN), addr_cnt $clog2(PRBS_MAX_CYCLES); no wrap beyond terminal values.
// CONFIGURATION
//  Macro BER_SYNC_AUTO_RESYNC_EN:
//  - defined: in BER, count strobes up to RESYNC_HOLDOFF (saturating).
//    Once saturated, if i_ber_ok=0 on a strobe: pulse o_ber_clr for one clk, reset LFSR to PRBS_SEED, -> IDLE.
//  - undefined: i_ber_ok ignored, o_ber_clr tied 0, holdoff counter absent.
// STRUCTURE
//  - Package ber_sync_pkg: state encodings (ST_IDLE/ST_SYNC/ST_BER), PRBS9 tap constants, default seed.
//  - Sub-module prbs9_gen (clk, i_reset, i_load_seed, i_step, o_bit); remaining FSM/counters inline.
// TESTING
//  1 Reset then i_en_rx=1, i_ctrl every 4 clk, WINDOW_LEN=8, PRBS_MAX_CYCLES=5
//    -> 5 done pulses 8 strobes apart, then ber_counter_en=1 after strobe 40.
//  2 PRBS check: seed 9'h1AA, 511 strobes in SYNC
//    -> o_prbs_bit matches golden PRBS9 model, period 511, LFSR never 0.
//  3 Deassert i_en_rx at window 3 strobe 5 -> all outputs 0 next clk; re-enable -> sweep restarts at addr 0.
//  4 i_ctrl held 0 for 100 clk mid-window -> outputs and LFSR unchanged.
//  5 With counter instantiated, rx = reference delayed 37 strobes -> counter locks r_lat=37, o_ber_ok_led=1.
//  6 AUTO_RESYNC_EN, RESYNC_HOLDOFF=16: i_ber_ok=0 at BER strobe 20
//    -> one-clk o_ber_clr, state IDLE, new sweep; i_ber_ok=0 at strobe 10 -> no action.

Source files
------------

// File: rtl/ber_sync_pkg.sv
// ============================================================================
//  Module      : ber_sync_pkg
//  Description : Shared state encodings, PRBS9 constants and helper functions
//                for the BER sync controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ber_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_BER  = 2'd2
    } state_t;

    // x^9 + x^5 + 1 : feedback taps at lfsr[8] and lfsr[4]
    localparam int         c_prbs9_tap_a        = 8;
    localparam int         c_prbs9_tap_b        = 4;
    localparam logic [8:0] c_prbs9_default_seed = 9'h1AA;

    function automatic logic [8:0] prbs9_next(input logic [8:0] s);
        return {s[7:0], s[c_prbs9_tap_a] ^ s[c_prbs9_tap_b]};
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ber_sync_ctrl_if.sv
// ============================================================================
//  Module      : ber_sync_ctrl_if
//  Description : Receive-control inputs and counter-facing outputs of the
//                BER sync controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ber_sync_ctrl_if;
    logic i_en_rx;
    logic i_ctrl;
    logic i_ber_ok;
    logic o_prbs_bit;
    logic o_synchro_en;
    logic o_prbs_cmp_curr_addr_done;
    logic o_ber_counter_en;
    logic o_ber_clr;
    logic o_sync_done;

    modport master (
        output i_en_rx, i_ctrl, i_ber_ok,
        input  o_prbs_bit, o_synchro_en, o_prbs_cmp_curr_addr_done,
               o_ber_counter_en, o_ber_clr, o_sync_done
    );

    modport slave (
        input  i_en_rx, i_ctrl, i_ber_ok,
        output o_prbs_bit, o_synchro_en, o_prbs_cmp_curr_addr_done,
               o_ber_counter_en, o_ber_clr, o_sync_done
    );
endinterface

`default_nettype wire

// File: rtl/ber_sync_ctrl_prbs9_gen.sv
// ============================================================================
//  Module      : prbs9_gen
//  Description : PRBS9 (x^9+x^5+1) reference generator with seed load and
//                strobe-gated stepping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs9_gen
    import ber_sync_pkg::*;
#(
    parameter logic [8:0] SEED = c_prbs9_default_seed
) (
    input  wire logic clk,
    input  wire logic i_reset,
    input  wire logic i_load_seed,
    input  wire logic i_step,
    output logic      o_bit
);

    logic [8:0] r_lfsr;
    logic       r_bit;
    logic [8:0] w_lfsr_next;

    assign w_lfsr_next = prbs9_next(r_lfsr);

    // The output bit reads 0 until the first step, then tracks lfsr[8]
    always_ff @(posedge clk) begin
        if (i_reset || i_load_seed) begin
            r_lfsr <= SEED;
            r_bit  <= 1'b0;
        end else if (i_step) begin
            r_lfsr <= w_lfsr_next;
            r_bit  <= w_lfsr_next[8];
        end
    end

    assign o_bit = r_bit;

endmodule

`default_nettype wire

// File: rtl/ber_sync_ctrl.sv
// ============================================================================
//  Module      : ber_sync_ctrl
//  Description : Latency-sweep sequencer and PRBS9 reference source for the
//                BER counter. Optional macro: BER_SYNC_AUTO_RESYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ber_sync_ctrl
    import ber_sync_pkg::*;
#(
    parameter int         PRBS_MAX_CYCLES = 511,
    parameter int         WINDOW_LEN      = 511,
    parameter logic [8:0] PRBS_SEED       = c_prbs9_default_seed,
    parameter int         RESYNC_HOLDOFF  = 4096
) (
    input  wire logic      clk,
    input  wire logic      i_reset,
    ber_sync_ctrl_if.slave bus
);

    localparam int c_win_w  = cnt_width(WINDOW_LEN);
    localparam int c_addr_w = cnt_width(PRBS_MAX_CYCLES);

    localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(WINDOW_LEN - 1);
    localparam logic [c_win_w-1:0]  c_win_pre   = c_win_w'(WINDOW_LEN - 2);
    localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(PRBS_MAX_CYCLES - 1);

    state_t              r_state;
    logic [c_win_w-1:0]  r_win_cnt;
    logic [c_addr_w-1:0] r_addr_cnt;
    logic                r_synchro_en;
    logic                r_addr_done;
    logic                r_ber_counter_en;
    logic                r_sync_done;
    logic                r_ber_clr;

    logic w_clear;
    logic w_resync;
    logic w_prbs_step;
    logic w_prbs_bit;

    assign w_clear     = i_reset || !bus.i_en_rx;
    assign w_prbs_step = bus.i_ctrl && (r_state != ST_IDLE);

`ifdef BER_SYNC_AUTO_RESYNC_EN
    localparam int c_hold_w = cnt_width(RESYNC_HOLDOFF + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(RESYNC_HOLDOFF);

    logic [c_hold_w-1:0] r_holdoff;
    logic                w_hold_sat;

    assign w_hold_sat = (r_holdoff == c_hold_max);
    assign w_resync   = bus.i_ctrl && (r_state == ST_BER) && w_hold_sat && !bus.i_ber_ok;

    // i_ber_ok is only trusted once the counter has seen a full holdoff of BER strobes
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_holdoff <= '0;
        end else if (bus.i_ctrl && (r_state == ST_BER)) begin
            if (w_resync)
                r_holdoff <= '0;
            else if (!w_hold_sat)
                r_holdoff <= r_holdoff + 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_resync = 1'b0;
    assign w_unused = bus.i_ber_ok ^ (RESYNC_HOLDOFF != 0);
`endif

    prbs9_gen #(
        .SEED (PRBS_SEED)
    ) u_prbs9_gen (
        .clk         (clk),
        .i_reset     (w_clear),
        .i_load_seed (w_resync),
        .i_step      (w_prbs_step),
        .o_bit       (w_prbs_bit)
    );

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state          <= ST_IDLE;
            r_win_cnt        <= '0;
            r_addr_cnt       <= '0;
            r_synchro_en     <= 1'b0;
            r_addr_done      <= 1'b0;
            r_ber_counter_en <= 1'b0;
            r_sync_done      <= 1'b0;
            r_ber_clr        <= 1'b0;
        end else begin
            r_ber_clr <= 1'b0;
            if (bus.i_ctrl) begin
                case (r_state)
                    ST_IDLE: begin
                        r_state      <= ST_SYNC;
                        r_synchro_en <= 1'b1;
                        r_win_cnt    <= '0;
                        r_addr_cnt   <= '0;
                    end
                    ST_SYNC: begin
                        if (r_win_cnt == c_win_last) begin
                            r_addr_done <= 1'b0;
                            r_win_cnt   <= '0;
                            if (r_addr_cnt == c_addr_last) begin
                                r_state          <= ST_BER;
                                r_synchro_en     <= 1'b0;
                                r_ber_counter_en <= 1'b1;
                                r_sync_done      <= 1'b1;
                            end else begin
                                r_addr_cnt <= r_addr_cnt + 1'b1;
                            end
                        end else begin
                            r_win_cnt   <= r_win_cnt + 1'b1;
                            // done level covers the last strobe interval of the window
                            r_addr_done <= (r_win_cnt == c_win_pre);
                        end
                    end
                    ST_BER: begin
                        if (w_resync) begin
                            r_state          <= ST_IDLE;
                            r_ber_counter_en <= 1'b0;
                            r_sync_done      <= 1'b0;
                            r_ber_clr        <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_prbs_bit                = w_prbs_bit;
    assign bus.o_synchro_en              = r_synchro_en;
    assign bus.o_prbs_cmp_curr_addr_done = r_addr_done;
    assign bus.o_ber_counter_en          = r_ber_counter_en;
    assign bus.o_ber_clr                 = r_ber_clr;
    assign bus.o_sync_done               = r_sync_done;

endmodule

`default_nettype wire
